// File: rtl/controller_port_pkg.sv
// Shared types and constants for the NES joypad port block.
// Button order, register selects and the default open-bus value.
package ControllerPkg;

   typedef enum logic [2:0] {
      BTN_A,
      BTN_B,
      BTN_SELECT,
      BTN_START,
      BTN_UP,
      BTN_DOWN,
      BTN_LEFT,
      BTN_RIGHT
   } btn_e;

   localparam logic REG_JOY1 = 1'b0;
   localparam logic REG_JOY2 = 1'b1;

   localparam logic [7:0] OPEN_BUS_DEF = 8'h40;

endpackage

// File: rtl/controller_port_if.sv
// CPU-side access bundle for the joypad registers $4016/$4017.
// cs_n/addr/rw/data_in come from the CPU; data_out returns to it.
interface controller_port_if;
   import ControllerPkg::*;

   logic       cs_n;
   logic       addr;
   logic       rw;
   logic [7:0] data_in;
   logic [7:0] data_out;

   modport master (
      output cs_n, addr, rw, data_in,
      input  data_out
   );

   modport slave (
      input  cs_n, addr, rw, data_in,
      output data_out
   );

endinterface

// File: rtl/controller_shift_reg.sv
// One joypad port: button synchroniser, 4021-style shift register,
// saturating shift counter. Ports: clk, reset, load, shift,
// buttons_async in; bit0 (current serial bit), count out.
module controller_shift_reg
   import ControllerPkg::*;
#(
   parameter int   SYNC_STAGES = 2,
   parameter logic EMPTY_BIT   = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic       shift,
   input  logic [7:0] buttons_async,
   output logic       bit0,
   output logic [3:0] count
);

   logic [7:0] sync_q [SYNC_STAGES];
   logic [7:0] sr_q, sr_d;
   logic [3:0] cnt_q, cnt_d;

   // load wins over shift: while strobe is high the port is transparent
   always_comb begin
      sr_d  = sr_q;
      cnt_d = cnt_q;
      if (load) begin
         sr_d  = sync_q[SYNC_STAGES-1];
         cnt_d = 4'd0;
      end else if (shift) begin
         sr_d  = {EMPTY_BIT, sr_q[7:1]};
         cnt_d = (cnt_q == 4'd8) ? 4'd8 : cnt_q + 4'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < SYNC_STAGES; i++)
            sync_q[i] <= '0;
         sr_q  <= 8'hFF;
         cnt_q <= 4'd8;
      end else begin
         sync_q[0] <= buttons_async;
         for (int i = 1; i < SYNC_STAGES; i++)
            sync_q[i] <= sync_q[i-1];
         sr_q  <= sr_d;
         cnt_q <= cnt_d;
      end
   end

   assign bit0  = sr_q[BTN_A];
   assign count = cnt_q;

endmodule

// File: rtl/controller_port.sv
// NES joypad responder: decodes $4016/$4017 accesses, holds the
// strobe latch and muxes the two serial ports onto the read bus.
// Ports: clk, reset, bus (slave), buttons_p1/p2 in; strobe,
// read_count_p1 out.
module controller_port
   import ControllerPkg::*;
#(
   parameter int         SYNC_STAGES = 2,
   parameter logic [7:0] OPEN_BUS    = OPEN_BUS_DEF,
   parameter logic       EMPTY_BIT   = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   controller_port_if.slave  bus,
   input  logic [7:0]        buttons_p1,
   input  logic [7:0]        buttons_p2,
   output logic              strobe,
   output logic [3:0]        read_count_p1
);

   logic acc, acc_q;
   logic rw_q, addr_q;
   logic strobe_q, strobe_d;
   logic acc_end, wr_start;
   logic shift1, shift2;
   logic bit1, bit2, bit_sel;
   logic [3:0] unused_cnt2;
   logic [6:0] unused_din;

   assign acc      = ~bus.cs_n;
   assign acc_end  = acc_q & ~acc;
   assign wr_start = acc & ~acc_q & ~bus.rw & (bus.addr == REG_JOY1);

   always_comb begin
      strobe_d = strobe_q;
      if (wr_start)
         strobe_d = bus.data_in[0];
   end

   // rw/addr are held from the last selected cycle for the end-of-access shift
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_q    <= 1'b0;
         rw_q     <= 1'b0;
         addr_q   <= 1'b0;
         strobe_q <= 1'b0;
      end else begin
         acc_q    <= acc;
         strobe_q <= strobe_d;
         if (acc) begin
            rw_q   <= bus.rw;
            addr_q <= bus.addr;
         end
      end
   end

   assign shift1 = ~strobe_q & acc_end & rw_q & (addr_q == REG_JOY1);
   assign shift2 = ~strobe_q & acc_end & rw_q & (addr_q == REG_JOY2);

   controller_shift_reg #(
      .SYNC_STAGES (SYNC_STAGES),
      .EMPTY_BIT   (EMPTY_BIT)
   ) u_p1 (
      .clk           (clk),
      .reset         (reset),
      .load          (strobe_q),
      .shift         (shift1),
      .buttons_async (buttons_p1),
      .bit0          (bit1),
      .count         (read_count_p1)
   );

   controller_shift_reg #(
      .SYNC_STAGES (SYNC_STAGES),
      .EMPTY_BIT   (EMPTY_BIT)
   ) u_p2 (
      .clk           (clk),
      .reset         (reset),
      .load          (strobe_q),
      .shift         (shift2),
      .buttons_async (buttons_p2),
      .bit0          (bit2),
      .count         (unused_cnt2)
   );

   assign unused_din = bus.data_in[7:1];
   assign bit_sel    = (bus.addr == REG_JOY2) ? bit2 : bit1;

   // reset also blanks the read bus so a held access shows 00
   assign bus.data_out = (acc & bus.rw & ~reset)
                         ? {OPEN_BUS[7:1], bit_sel} : 8'h00;
   assign strobe       = strobe_q;

endmodule

// File: tb/tb_controller_port.sv
// Randomised and directed bench for controller_port with an
// index-into-latched-byte reference model.
module tb_controller_port;
   import ControllerPkg::*;

   localparam int SYNC = 2;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] buttons_p1 = 8'h00;
   logic [7:0] buttons_p2 = 8'h00;
   logic       strobe;
   logic [3:0] read_count_p1;

   int n_checks = 0;
   int n_fail   = 0;

   controller_port_if bus ();

   controller_port #(
      .SYNC_STAGES (SYNC),
      .OPEN_BUS    (8'h40),
      .EMPTY_BIT   (1'b1)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .bus           (bus),
      .buttons_p1    (buttons_p1),
      .buttons_p2    (buttons_p2),
      .strobe        (strobe),
      .read_count_p1 (read_count_p1)
   );

   always #5 clk = ~clk;

   // model: each port holds a frozen byte and how many bits were consumed
   logic [7:0] h1 [SYNC];
   logic [7:0] h2 [SYNC];
   logic [7:0] snap [2];
   int         idx [2];
   logic       m_strobe, m_acc, m_rd, m_port;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < SYNC; i++) begin
            h1[i] <= 8'h00;
            h2[i] <= 8'h00;
         end
         snap[0]  <= 8'hFF;
         snap[1]  <= 8'hFF;
         idx[0]   <= 8;
         idx[1]   <= 8;
         m_strobe <= 1'b0;
         m_acc    <= 1'b0;
         m_rd     <= 1'b0;
         m_port   <= 1'b0;
      end else begin
         h1[0] <= buttons_p1;
         h2[0] <= buttons_p2;
         for (int i = 1; i < SYNC; i++) begin
            h1[i] <= h1[i-1];
            h2[i] <= h2[i-1];
         end
         if (m_strobe) begin
            snap[0] <= h1[SYNC-1];
            snap[1] <= h2[SYNC-1];
            idx[0]  <= 0;
            idx[1]  <= 0;
         end else if (m_acc && bus.cs_n && m_rd) begin
            idx[m_port] <= (idx[m_port] >= 8) ? 8 : idx[m_port] + 1;
         end
         if (!bus.cs_n && !m_acc && !bus.rw && !bus.addr)
            m_strobe <= bus.data_in[0];
         m_acc <= !bus.cs_n;
         if (!bus.cs_n) begin
            m_rd   <= bus.rw;
            m_port <= bus.addr;
         end
      end
   end

   function automatic logic ebit(input logic p);
      int k;
      k = idx[p];
      if (k >= 8) return 1'b1;
      return snap[p][k];
   endfunction

   // per-cycle compare against the model
   always @(negedge clk) begin
      logic [7:0] exp_do;
      exp_do = (!reset && !bus.cs_n && bus.rw)
               ? {7'b0100000, ebit(bus.addr)} : 8'h00;
      n_checks++;
      if (bus.data_out !== exp_do) begin
         n_fail++;
         $display("FAIL data_out t=%0t got %h exp %h", $time,
                  bus.data_out, exp_do);
      end
      n_checks++;
      if (strobe !== m_strobe) begin
         n_fail++;
         $display("FAIL strobe t=%0t got %b exp %b", $time,
                  strobe, m_strobe);
      end
      n_checks++;
      if (read_count_p1 !== 4'(idx[0])) begin
         n_fail++;
         $display("FAIL read_count_p1 t=%0t got %0d exp %0d", $time,
                  read_count_p1, idx[0]);
      end
   end

   task automatic chk(input string nm, input logic [7:0] got,
                      input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got %h exp %h", nm, got, exp);
      end
   endtask

   task automatic cyc(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(input logic a, input logic [7:0] v);
      bus.cs_n = 1'b0;
      bus.rw = 1'b0;
      bus.addr = a;
      bus.data_in = v;
      cyc();
      bus.cs_n = 1'b1;
      bus.rw = 1'b1;
      cyc();
   endtask

   task automatic rd(input logic a, input int len, output logic [7:0] d);
      bus.cs_n = 1'b0;
      bus.rw = 1'b1;
      bus.addr = a;
      @(negedge clk);
      d = bus.data_out;
      cyc(len);
      bus.cs_n = 1'b1;
      cyc();
   endtask

   logic [7:0] d;
   logic [7:0] exp1 [8];

   initial begin
      bus.cs_n = 1'b1;
      bus.rw = 1'b1;
      bus.addr = 1'b0;
      bus.data_in = 8'h00;
      #2;
      @(negedge clk);
      chk("reset_dout", bus.data_out, 8'h00);
      chk("reset_cnt", {4'h0, read_count_p1}, 8'h08);
      chk("reset_strobe", {7'h0, strobe}, 8'h00);
      cyc();
      reset = 1'b0;
      cyc();

      // 1: basic read-out
      buttons_p1 = 8'b1000_1001;
      cyc(3);
      wr(1'b0, 8'h01);
      cyc(2);
      wr(1'b0, 8'h00);
      exp1 = '{8'h41, 8'h40, 8'h40, 8'h41, 8'h40, 8'h40, 8'h40, 8'h41};
      for (int i = 0; i < 8; i++) begin
         rd(1'b0, 1, d);
         chk($sformatf("basic_rd%0d", i), d, exp1[i]);
      end
      @(negedge clk);
      chk("basic_cnt", {4'h0, read_count_p1}, 8'h08);

      // 2: empty-bit fill
      cyc();
      for (int i = 0; i < 3; i++) begin
         rd(1'b0, 1, d);
         chk($sformatf("empty_rd%0d", i), d, 8'h41);
      end
      @(negedge clk);
      chk("empty_cnt", {4'h0, read_count_p1}, 8'h08);

      // 3: strobe held high, live A
      cyc();
      buttons_p1 = 8'h00;
      wr(1'b0, 8'h01);
      cyc(3);
      rd(1'b0, 1, d);
      chk("strobe_rd0", d, 8'h40);
      buttons_p1 = 8'h01;
      cyc(3);
      for (int i = 0; i < 4; i++) begin
         rd(1'b0, 1, d);
         chk($sformatf("strobe_rd%0d", i + 1), d, 8'h41);
      end
      @(negedge clk);
      chk("strobe_cnt", {4'h0, read_count_p1}, 8'h00);

      // 4: multi-cycle access, one shift
      cyc();
      buttons_p1 = 8'b0000_0010;
      cyc(3);
      wr(1'b0, 8'h00);
      rd(1'b0, 4, d);
      chk("multi_rd", d, 8'h40);
      @(negedge clk);
      chk("multi_cnt", {4'h0, read_count_p1}, 8'h01);
      rd(1'b0, 1, d);
      chk("multi_next", d, 8'h41);

      // 5: port independence
      cyc();
      buttons_p1 = 8'h00;
      buttons_p2 = 8'hFF;
      cyc(3);
      wr(1'b0, 8'h01);
      cyc();
      wr(1'b0, 8'h00);
      rd(1'b1, 1, d);
      chk("indep_p2a", d, 8'h41);
      rd(1'b1, 1, d);
      chk("indep_p2b", d, 8'h41);
      rd(1'b0, 1, d);
      chk("indep_p1", d, 8'h40);
      @(negedge clk);
      chk("indep_cnt", {4'h0, read_count_p1}, 8'h01);

      // 6: reset mid-sequence
      cyc();
      for (int i = 0; i < 2; i++) rd(1'b0, 1, d);
      bus.cs_n = 1'b0;
      bus.rw = 1'b1;
      bus.addr = 1'b0;
      cyc();
      reset = 1'b1;
      #1;
      chk("rst_dout", bus.data_out, 8'h00);
      chk("rst_cnt", {4'h0, read_count_p1}, 8'h08);
      cyc(2);
      reset = 1'b0;
      cyc(2);
      bus.cs_n = 1'b1;
      cyc();
      rd(1'b0, 1, d);
      chk("rst_after", d, 8'h41);

      // random traffic
      for (int t = 0; t < 400; t++) begin
         int op;
         op = int'($urandom_range(0, 9));
         if ($urandom_range(0, 3) == 0) buttons_p1 = 8'($urandom);
         if ($urandom_range(0, 3) == 0) buttons_p2 = 8'($urandom);
         if (op == 0)
            wr(1'b0, 8'($urandom));
         else if (op == 1)
            wr(1'b1, 8'($urandom));
         else if (op == 2)
            cyc(int'($urandom_range(1, 3)));
         else
            rd(1'($urandom), int'($urandom_range(1, 3)), d);
      end
      cyc(2);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
